// File: rtl/vga_pkg.sv
// Shared VGA timing constants (640x480@60) and the helper that sums an axis's segments.
package vga_pkg;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;
  localparam int unsigned DEF_CNT_W    = 10;

  function automatic int unsigned axis_total(input int unsigned active,
                                             input int unsigned fp,
                                             input int unsigned sync,
                                             input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrap counter with advance input, terminal count and sync/active window decode.
// Decodes are combinational on pos; pos steps once per cycle with adv high and holds otherwise.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int unsigned ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned FP     = DEF_H_FP,
  parameter int unsigned SYNC   = DEF_H_SYNC,
  parameter int unsigned BP     = DEF_H_BP,
  parameter int unsigned W      = DEF_CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         adv,
  output logic [W-1:0] pos,
  output logic         tc,
  output logic         in_sync,
  output logic         in_active
);

  localparam int unsigned TOTAL = axis_total(ACTIVE, FP, SYNC, BP);
  localparam logic [W-1:0] LAST    = W'(TOTAL - 1);
  localparam logic [W-1:0] SYNC_LO = W'(ACTIVE + FP);
  localparam logic [W-1:0] SYNC_HI = W'(ACTIVE + FP + SYNC - 1);
  localparam logic [W-1:0] ACT_END = W'(ACTIVE);
  localparam logic [W-1:0] ONE     = W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos <= '0;
    end else if (adv) begin
      pos <= tc ? '0 : pos + ONE;
    end
  end

  assign tc        = (pos == LAST);
  assign in_sync   = (pos >= SYNC_LO) && (pos <= SYNC_HI);
  assign in_active = (pos < ACT_END);

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator; all outputs decode hpos/vpos with zero latency.
// Define VGA_TIMING_FRAME_CNT_EN to add an 8-bit frame counter output (frame_cnt).
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
  parameter int unsigned H_FP       = DEF_H_FP,
  parameter int unsigned H_SYNC     = DEF_H_SYNC,
  parameter int unsigned H_BP       = DEF_H_BP,
  parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE,
  parameter int unsigned V_FP       = DEF_V_FP,
  parameter int unsigned V_SYNC     = DEF_V_SYNC,
  parameter int unsigned V_BP       = DEF_V_BP,
  parameter bit          H_SYNC_POL = 1'b0,
  parameter bit          V_SYNC_POL = 1'b0,
  parameter int unsigned CNT_W      = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pix_en,
  output logic [CNT_W-1:0] hpos,
  output logic [CNT_W-1:0] vpos,
  output logic             hsync,
  output logic             vsync,
  output logic             display_on,
  output logic             line_start,
`ifdef VGA_TIMING_FRAME_CNT_EN
  output logic             frame_start,
  output logic [7:0]       frame_cnt
`else
  output logic             frame_start
`endif
);

  logic h_tc, h_sync_win, h_act;
  logic v_sync_win, v_act;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic v_tc;
`endif

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .W(CNT_W)
  ) u_h (
    .clk       (clk),
    .rst_n     (rst_n),
    .adv       (pix_en),
    .pos       (hpos),
    .tc        (h_tc),
    .in_sync   (h_sync_win),
    .in_active (h_act)
  );

  // Vertical axis steps only on the pixel that ends a line, so vsync moves with the hpos wrap.
  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .W(CNT_W)
  ) u_v (
    .clk       (clk),
    .rst_n     (rst_n),
    .adv       (pix_en && h_tc),
    .pos       (vpos),
`ifdef VGA_TIMING_FRAME_CNT_EN
    .tc        (v_tc),
`else
    .tc        (),
`endif
    .in_sync   (v_sync_win),
    .in_active (v_act)
  );

  assign hsync       = h_sync_win ? H_SYNC_POL : ~H_SYNC_POL;
  assign vsync       = v_sync_win ? V_SYNC_POL : ~V_SYNC_POL;
  assign display_on  = h_act && v_act;
  assign line_start  = pix_en && (hpos == '0);
  assign frame_start = line_start && (vpos == '0);

`ifdef VGA_TIMING_FRAME_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (pix_en && h_tc && v_tc) begin
      frame_cnt <= frame_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench: default 640x480 instance plus a tiny 7x5 instance, compared each cycle to a pixel-count model.
module tb_vga_timing_gen;

  localparam int DH_T = 800, DV_T = 525;
  localparam int SH_T = 7,   SV_T = 5;

  logic clk = 1'b0;
  logic rst_n, pix_en;

  logic [9:0] hpos_d, vpos_d;
  logic hsync_d, vsync_d, disp_d, ls_d, fs_d;
  logic [3:0] hpos_s, vpos_s;
  logic hsync_s, vsync_s, disp_s, ls_s, fs_s;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [7:0] fcnt_d, fcnt_s;
`endif

  always #5 clk = ~clk;

  vga_timing_gen u_dut_d (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
    .hpos(hpos_d), .vpos(vpos_d), .hsync(hsync_d), .vsync(vsync_d),
    .display_on(disp_d), .line_start(ls_d),
`ifdef VGA_TIMING_FRAME_CNT_EN
    .frame_cnt(fcnt_d),
`endif
    .frame_start(fs_d)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(0), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(0),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b0), .CNT_W(4)
  ) u_dut_s (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
    .hpos(hpos_s), .vpos(vpos_s), .hsync(hsync_s), .vsync(vsync_s),
    .display_on(disp_s), .line_start(ls_s),
`ifdef VGA_TIMING_FRAME_CNT_EN
    .frame_cnt(fcnt_s),
`endif
    .frame_start(fs_s)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      if (bad <= 30) $display("FAIL %s got=%0d expected=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model state: number of accepted pixel enables since reset, and clock count.
  longint n = 0;
  longint cyc = 0;
  int phase = 0;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) n <= 0;
    else if (pix_en) n <= n + 1;

  always @(posedge clk) cyc <= cyc + 1;

  longint eh, ev, sh, sv;
  longint last_ls_d = 0, last_ls_s = 0, last_fs_s = 0;
  int ph_ls_d = -1, ph_ls_s = -1, ph_fs_s = -1;
  logic wrap_pend = 1'b0;

  always @(negedge clk) begin
    eh = n % DH_T;
    ev = (n / DH_T) % DV_T;
    sh = n % SH_T;
    sv = (n / SH_T) % SV_T;

    chk("d_hpos", hpos_d, eh);
    chk("d_vpos", vpos_d, ev);
    chk("d_hsync", hsync_d, (eh >= 656 && eh <= 751) ? 0 : 1);
    chk("d_vsync", vsync_d, (ev >= 490 && ev <= 491) ? 0 : 1);
    chk("d_disp", disp_d, (eh < 640 && ev < 480) ? 1 : 0);
    chk("d_line_start", ls_d, (eh == 0 && pix_en) ? 1 : 0);
    chk("d_frame_start", fs_d, (eh == 0 && ev == 0 && pix_en) ? 1 : 0);

    chk("s_hpos", hpos_s, sh);
    chk("s_vpos", vpos_s, sv);
    chk("s_hsync", hsync_s, (sh >= 4 && sh <= 5) ? 1 : 0);
    chk("s_vsync", vsync_s, (sv == 4) ? 0 : 1);
    chk("s_disp", disp_s, (sh < 4 && sv < 3) ? 1 : 0);
    chk("s_line_start", ls_s, (sh == 0 && pix_en) ? 1 : 0);
    chk("s_frame_start", fs_s, (sh == 0 && sv == 0 && pix_en) ? 1 : 0);
`ifdef VGA_TIMING_FRAME_CNT_EN
    chk("d_frame_cnt", fcnt_d, (n / (DH_T * DV_T)) % 256);
    chk("s_frame_cnt", fcnt_s, (n / (SH_T * SV_T)) % 256);
    if (n == 257 * SH_T * SV_T) chk("s_frame_cnt_257", fcnt_s, 1);
`endif

    // Literal pins on the timing windows, independent of the model.
    if (hpos_d == 10'd655) chk("d_hsync_655", hsync_d, 1);
    if (hpos_d == 10'd656) chk("d_hsync_656", hsync_d, 0);
    if (hpos_d == 10'd751) chk("d_hsync_751", hsync_d, 0);
    if (hpos_d == 10'd752) chk("d_hsync_752", hsync_d, 1);
    if (hpos_d == 10'd640) chk("d_disp_640", disp_d, 0);
    if (hpos_s == 4'd3) chk("s_hsync_3", hsync_s, 0);
    if (hpos_s == 4'd4) chk("s_hsync_4", hsync_s, 1);
    if (hpos_s == 4'd5) chk("s_hsync_5", hsync_s, 1);
    if (hpos_s == 4'd6) chk("s_hsync_6", hsync_s, 0);
    if (wrap_pend) begin
      chk("s_wrap_h", hpos_s, 0);
      chk("s_wrap_v", vpos_s, 0);
    end
    wrap_pend = (hpos_s == 4'd6 && vpos_s == 4'd4 && pix_en && rst_n);

    if (ls_d) begin
      if (ph_ls_d == phase && (phase == 1 || phase == 2))
        chk("d_line_period", cyc - last_ls_d, (phase == 1) ? 800 : 1600);
      last_ls_d = cyc; ph_ls_d = phase;
    end
    if (ls_s) begin
      if (ph_ls_s == phase && (phase == 1 || phase == 2))
        chk("s_line_period", cyc - last_ls_s, (phase == 1) ? 7 : 14);
      last_ls_s = cyc; ph_ls_s = phase;
    end
    if (fs_s) begin
      if (ph_fs_s == phase && (phase == 1 || phase == 2))
        chk("s_frame_period", cyc - last_fs_s, (phase == 1) ? 35 : 70);
      last_fs_s = cyc; ph_fs_s = phase;
    end
  end

  initial begin
    logic found;
    rst_n = 1'b0;
    pix_en = 1'b0;
    #2;
    chk("rst0_hpos", hpos_d, 0);
    chk("rst0_vpos", vpos_d, 0);
    chk("rst0_disp", disp_d, 1);
    chk("rst0_hsync", hsync_d, 1);
    chk("rst0_ls", ls_d, 0);
    chk("rst0_s_hsync", hsync_s, 0);
    #5 rst_n = 1'b1;

    // Continuous pixel enable: one pixel per clock.
    @(posedge clk); #1;
    phase = 1;
    pix_en = 1'b1;
    repeat (2000) @(posedge clk);
    #1;

    // Async reset in the middle of a line, between clock edges.
    phase = 3;
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(posedge clk); #1;
      if (hpos_d == 10'd300) found = 1'b1;
    end
    chk("reach_hpos_300", found, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_hpos", hpos_d, 0);
    chk("arst_vpos", vpos_d, 0);
    chk("arst_disp", disp_d, 1);
    chk("arst_hsync", hsync_d, 1);
    chk("arst_vsync", vsync_d, 1);
    chk("arst_s_hpos", hpos_s, 0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_hpos", hpos_d, 1);
    chk("rel_s_hpos", hpos_s, 1);

    // Alternating enable: every pixel takes two clocks.
    phase = 2;
    repeat (3500) begin
      pix_en = ~pix_en;
      @(posedge clk); #1;
    end

    // Random enable.
    phase = 0;
    repeat (30000) begin
      pix_en = ($urandom_range(3) != 0);
      @(posedge clk); #1;
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
